// File: rtl/dot_acc_8.sv
// dot_acc_8: streaming 8x8 unsigned dot-product accumulator (dadda_8 multiply, valid/ready in/out).
// Ports: clk, rst (async, active high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with acc_out (ACC_W bits) and out_ovf (sticky overflow for the vector).
// Optional feature: define DOT_ACC_SAT_EN to clamp the accumulator to all ones on overflow
// instead of wrapping modulo 2^ACC_W.

module dadda_8 (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) p = p + (b[i] ? ({8'b0, a} << i) : 16'b0);
   end
endmodule

module dot_acc_8 #(
   parameter int N_TERMS = 16,
   parameter int ACC_W   = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_ovf
);
   localparam int CW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] a_q, a_d, b_q, b_d;
   logic v1_q, v1_d, v2_q, v2_d;
   logic [15:0] p_q, p_d, prod;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic ovf_q, ovf_d;
   logic [ACC_W:0] sum;
   logic in_xfer, out_xfer, last;
   dadda_8 u_mul (.a(a_q), .b(b_q), .p(prod));
   always_comb begin
      in_ready  = state_q == ACC;
      out_valid = state_q == OUT;
      acc_out   = acc_q;
      out_ovf   = ovf_q;
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      last      = cnt_q == CW'(N_TERMS - 1);
      sum       = {1'b0, acc_q} + (ACC_W+1)'(p_q);
      a_d  = in_xfer ? a : a_q;
      b_d  = in_xfer ? b : b_q;
      v1_d = in_xfer;
      v2_d = v1_q;
      p_d  = v1_q ? prod : p_q;
      cnt_d = in_xfer ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
      ovf_d = ovf_q | (v2_q & sum[ACC_W]);
`ifdef DOT_ACC_SAT_EN
      acc_d = !v2_q ? acc_q : ((sum[ACC_W] || ovf_q) ? '1 : sum[ACC_W-1:0]);
`else
      acc_d = v2_q ? sum[ACC_W-1:0] : acc_q;
`endif
      state_d = state_q;
      if (state_q == ACC && in_xfer && last) state_d = DRAIN;
      // The last term is in p_q and nothing is behind it: it lands in acc on this edge.
      if (state_q == DRAIN && v2_q && !v1_q) state_d = OUT;
      if (out_xfer) begin
         state_d = ACC;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACC;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         p_q     <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_dot_acc_8.sv
// tb_dot_acc_8: scoreboard bench for dot_acc_8 with three parameterisations (4x24, 16x24, 2x16).
module tb_dot_acc_8;
   logic clk = 0, rst = 1;
   logic [2:0] vin = '0, rdy = 3'b111;
   logic [7:0] ain [3];
   logic [7:0] bin [3];
   logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
   logic [23:0] acc0, acc1;
   logic [15:0] acc2;
   int checks = 0, errors = 0, cyc = 0, last_acc = 0;
   logic [24:0] q0[$], q1[$];
   logic [16:0] q2[$];
   logic [24:0] e0, e1;
   logic [16:0] e2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dot_acc_8 #(.N_TERMS(4), .ACC_W(24)) u4 (.clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(ir0),
      .a(ain[0]), .b(bin[0]), .out_valid(ov0), .out_ready(rdy[0]), .acc_out(acc0), .out_ovf(of0));
   dot_acc_8 u16 (.clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(ir1),
      .a(ain[1]), .b(bin[1]), .out_valid(ov1), .out_ready(rdy[1]), .acc_out(acc1), .out_ovf(of1));
   dot_acc_8 #(.N_TERMS(2), .ACC_W(16)) u2 (.clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(ir2),
      .a(ain[2]), .b(bin[2]), .out_valid(ov2), .out_ready(rdy[2]), .acc_out(acc2), .out_ovf(of2));

   task automatic check(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   function automatic logic ready(input int d);
      return d == 0 ? ir0 : (d == 1 ? ir1 : ir2);
   endfunction

   function automatic logic valid(input int d);
      return d == 0 ? ov0 : (d == 1 ? ov1 : ov2);
   endfunction

   task automatic send(input int d, input logic [7:0] x, input logic [7:0] y);
      logic took;
      int n = 0;
      ain[d] = x;
      bin[d] = y;
      vin[d] = 1'b1;
      do begin
         took = ready(d);
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 50);
      if (!took) check("accept_timeout", 0, 1);
      last_acc = cyc;
      vin[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_out(input int d);
      int n = 0;
      while (!valid(d) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("out_valid_latency", cyc - last_acc, 2);
   endtask

   always @(negedge clk) if (!rst && ov0 && rdy[0]) begin
      if (q0.size() == 0) check("unexpected_out_u4", 1, 0);
      else begin
         e0 = q0.pop_front();
         check("acc_u4", acc0, e0[23:0]);
         check("ovf_u4", of0, e0[24]);
      end
   end

   always @(negedge clk) if (!rst && ov1 && rdy[1]) begin
      if (q1.size() == 0) check("unexpected_out_u16", 1, 0);
      else begin
         e1 = q1.pop_front();
         check("acc_u16", acc1, e1[23:0]);
         check("ovf_u16", of1, e1[24]);
      end
   end

   always @(negedge clk) if (!rst && ov2 && rdy[2]) begin
      if (q2.size() == 0) check("unexpected_out_u2", 1, 0);
      else begin
         e2 = q2.pop_front();
         check("acc_u2", acc2, e2[15:0]);
         check("ovf_u2", of2, e2[16]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         ain[i] = '0;
         bin[i] = '0;
      end
      #3;
      check("reset_in_ready", ir0, 1);
      check("reset_out_valid", ov0, 0);
      check("reset_acc", acc0, 0);
      check("reset_ovf", of0, 0);
      @(posedge clk);
      #1 rst = 0;
      idle(1);
      // dot of (1,2,3,4) with 2 -> 20
      q0.push_back({1'b0, 24'd20});
      for (int i = 1; i <= 4; i++) send(0, 8'(i), 8'd2);
      wait_out(0);
      idle(3);
      // same vector with a bubble between terms
      q0.push_back({1'b0, 24'd20});
      for (int i = 1; i <= 4; i++) begin
         send(0, 8'(i), 8'd2);
         if (i < 4) idle(1);
      end
      wait_out(0);
      idle(3);
      // stalled output; operands offered in OUT must be ignored
      rdy[0] = 1'b0;
      q0.push_back({1'b0, 24'd20});
      for (int i = 1; i <= 4; i++) send(0, 8'(i), 8'd2);
      wait_out(0);
      ain[0] = 8'd99;
      bin[0] = 8'd99;
      vin[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("stall_acc", acc0, 20);
         check("stall_in_ready", ir0, 0);
         check("stall_out_valid", ov0, 1);
         idle(1);
      end
      vin[0] = 1'b0;
      rdy[0] = 1'b1;
      idle(1);
      check("ready_after_xfer", ir0, 1);
      check("valid_after_xfer", ov0, 0);
      q0.push_back({1'b0, 24'd4});
      for (int i = 0; i < 4; i++) send(0, 8'd1, 8'd1);
      wait_out(0);
      idle(3);
      // reset mid-vector discards the partial sum immediately
      send(0, 8'd3, 8'd3);
      send(0, 8'd3, 8'd3);
      idle(2);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", ov0, 0);
      check("midrst_acc", acc0, 0);
      check("midrst_ovf", of0, 0);
      check("midrst_in_ready", ir0, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      q0.push_back({1'b0, 24'd36});
      for (int i = 0; i < 4; i++) send(0, 8'd3, 8'd3);
      wait_out(0);
      idle(3);
      // 16 x 255*255 = 1040400
      q1.push_back({1'b0, 24'd1040400});
      for (int i = 0; i < 16; i++) send(1, 8'd255, 8'd255);
      wait_out(1);
      idle(3);
      // 2 x 255*255 overflows 16 bits
`ifdef DOT_ACC_SAT_EN
      q2.push_back({1'b1, 16'hFFFF});
`else
      q2.push_back({1'b1, 16'hFC02});
`endif
      send(2, 8'd255, 8'd255);
      send(2, 8'd255, 8'd255);
      wait_out(2);
      idle(4);
      check("q_u4_empty", q0.size(), 0);
      check("q_u16_empty", q1.size(), 0);
      check("q_u2_empty", q2.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
